// File: rtl/rsa_modexp_core_if.sv
// Register-bank to modexp-core handshake: operands in; result and status out.
interface rsa_modexp_core_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] e;
  logic [WIDTH-1:0] m;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] c;

  modport master (output start, p, e, m, input busy, done, err, c);
  modport slave  (input start, p, e, m, output busy, done, err, c);
endinterface

// File: rtl/rsa_modexp_core.sv
// Bit-serial modular exponentiation C = M^E mod P using left-to-right
// square-and-multiply over an interleaved shift-add modular multiplier.
// Optional macro RSA_CONST_TIME_EN: run MUL for every exponent bit and
// discard the product on zero bits, giving an exponent-independent latency.
module rsa_modexp_core #(
  parameter int unsigned WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  rsa_modexp_core_if.slave bus
);
  localparam int unsigned RW = WIDTH + 2;
  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    NORM = 3'd1,
    SQR  = 3'd2,
    MUL  = 3'd3,
    FIN  = 3'd4
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] e_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] base_q;
  logic [WIDTH-1:0] acc_q;
  logic [RW-1:0]    r_q;
  logic [IW-1:0]    i_q;
  logic [IW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic [WIDTH-1:0] c_q;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             a_bit;
  logic [RW-1:0]    pw;
  logic [RW-1:0]    sum0;
  logic [RW-1:0]    sum1;
  logic [RW-1:0]    r_next;
  logic [WIDTH-1:0] prod;
  logic             last;

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;
  assign bus.c    = c_q;

  // One multiplier iteration: R <- 2R + a_bit*B, then reduce below P.
  always_comb begin
    op_a = acc_q;
    op_b = acc_q;
    case (state)
      NORM:    begin op_a = m_q;   op_b = WIDTH'(1); end
      MUL:     begin op_a = acc_q; op_b = base_q;    end
      default: begin op_a = acc_q; op_b = acc_q;     end
    endcase
    a_bit  = op_a[cnt_q];
    pw     = RW'(p_q);
    sum0   = (r_q << 1) + (a_bit ? RW'(op_b) : RW'(0));
    sum1   = (sum0 >= pw) ? (sum0 - pw) : sum0;
    r_next = (sum1 >= pw) ? (sum1 - pw) : sum1;
    prod   = r_next[WIDTH-1:0];
    last   = (cnt_q == '0);
  end

  // Control FSM, multiplier sequencing and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      p_q    <= '0;
      e_q    <= '0;
      m_q    <= '0;
      base_q <= '0;
      acc_q  <= '0;
      r_q    <= '0;
      i_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      c_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (state == NORM || state == SQR || state == MUL) begin
        r_q   <= last ? '0 : r_next;
        cnt_q <= last ? IW'(WIDTH - 1) : (cnt_q - IW'(1));
      end
      case (state)
        IDLE: begin
          if (bus.start) begin
            p_q    <= bus.p;
            e_q    <= bus.e;
            m_q    <= bus.m;
            acc_q  <= (bus.p == WIDTH'(1)) ? '0 : WIDTH'(1);
            i_q    <= IW'(WIDTH - 1);
            cnt_q  <= IW'(WIDTH - 1);
            r_q    <= '0;
            busy_q <= 1'b1;
            if (bus.p == '0) begin
              err_q <= 1'b1;
              state <= FIN;
            end else begin
              err_q <= 1'b0;
              state <= NORM;
            end
          end
        end
        NORM: begin
          if (last) begin
            base_q <= prod;
            state  <= SQR;
          end
        end
        SQR: begin
          if (last) begin
            acc_q <= prod;
`ifdef RSA_CONST_TIME_EN
            state <= MUL;
`else
            if (e_q[i_q]) begin
              state <= MUL;
            end else if (i_q == '0) begin
              state <= FIN;
            end else begin
              i_q   <= i_q - IW'(1);
              state <= SQR;
            end
`endif
          end
        end
        MUL: begin
          if (last) begin
`ifdef RSA_CONST_TIME_EN
            if (e_q[i_q]) begin
              acc_q <= prod;
            end
`else
            acc_q <= prod;
`endif
            if (i_q == '0) begin
              state <= FIN;
            end else begin
              i_q   <= i_q - IW'(1);
              state <= SQR;
            end
          end
        end
        FIN: begin
          c_q    <= err_q ? '0 : acc_q;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rsa_modexp_core.sv
// Self-checking bench for rsa_modexp_core against a right-to-left
// exponentiation model and a closed-form latency formula.
module tb_rsa_modexp_core;
  localparam int unsigned W = 8;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  rsa_modexp_core_if #(.WIDTH(W)) bus ();

  rsa_modexp_core #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result: right-to-left binary exponentiation with plain modulo.
  function automatic logic [7:0] ref_modexp(input logic [7:0] m, input logic [7:0] e,
                                            input logic [7:0] p);
    int r;
    int b;
    if (p == 0) return 8'd0;
    r = 1 % int'(p);
    b = int'(m) % int'(p);
    for (int k = 0; k < 8; k++) begin
      if (e[k]) r = (r * b) % int'(p);
      b = (b * b) % int'(p);
    end
    return r[7:0];
  endfunction

  // Reference latency in cycles from the start edge to the done edge.
  function automatic int ref_lat(input logic [7:0] e, input logic [7:0] p);
    if (p == 0) return 1;
`ifdef RSA_CONST_TIME_EN
    return W * (1 + 2 * W) + 1;
`else
    return W * (1 + W + $countones(e)) + 1;
`endif
  endfunction

  // Launch one operation and observe it until done or a cycle budget expires.
  task automatic run_op(input logic [7:0] mi, input logic [7:0] ei, input logic [7:0] pi,
                        input int inj, output logic [7:0] oc, output logic oerr,
                        output int lat, output bit busy_ok, output bit c_stable);
    logic [7:0] c0;
    c0 = bus.c;
    bus.m = mi;
    bus.e = ei;
    bus.p = pi;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    busy_ok  = (bus.busy === 1'b1) && (bus.done === 1'b0);
    c_stable = (bus.c === c0);
    lat = -1;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      if (inj != 0 && cyc == inj) begin
        bus.start = 1'b1;
        bus.m = 8'd1;
        bus.e = 8'd1;
        bus.p = 8'd3;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        lat = cyc;
        if (bus.busy !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.c !== c0) c_stable = 1'b0;
    end
    bus.start = 1'b0;
    oc   = bus.c;
    oerr = bus.err;
  endtask

  // Compare one completed operation against the model.
  task automatic check_op(input string name, input logic [7:0] mi, input logic [7:0] ei,
                          input logic [7:0] pi, input int inj);
    logic [7:0] oc;
    logic       oerr;
    int         lat;
    bit         bok;
    bit         cst;
    run_op(mi, ei, pi, inj, oc, oerr, lat, bok, cst);
    n_vec++;
    if (oc !== ref_modexp(mi, ei, pi)) begin
      n_err++;
      $display("FAIL %s c: got %0d want %0d (m=%0d e=%0d p=%0d)", name, oc,
               ref_modexp(mi, ei, pi), mi, ei, pi);
    end
    n_vec++;
    if (oerr !== (pi == 8'd0)) begin
      n_err++;
      $display("FAIL %s err: got %0b want %0b", name, oerr, (pi == 8'd0));
    end
    n_vec++;
    if (lat != ref_lat(ei, pi)) begin
      n_err++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, ref_lat(ei, pi));
    end
    n_vec++;
    if (!bok) begin
      n_err++;
      $display("FAIL %s busy window: got bad want ok", name);
    end
    n_vec++;
    if (!cst) begin
      n_err++;
      $display("FAIL %s c stability: got changed want stable", name);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.m = '0;
    bus.e = '0;
    bus.p = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    n_vec++;
    if ({bus.busy, bus.done, bus.err, bus.c} !== 11'd0) begin
      n_err++;
      $display("FAIL reset state: got busy=%0b done=%0b err=%0b c=%0d want 0", bus.busy,
               bus.done, bus.err, bus.c);
    end
  endtask

  task automatic test_basic();
    check_op("basic_5_3_7", 8'd5, 8'd3, 8'd7, 0);
    @(posedge clk);
    #1;
    n_vec++;
    if (bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL done pulse width: got %0b want 0", bus.done);
    end
  endtask

  task automatic test_ignored_start();
    check_op("big_255_255_251", 8'd255, 8'd255, 8'd251, 50);
    n_vec++;
    if (bus.c !== 8'd20) begin
      n_err++;
      $display("FAIL big constant: got %0d want 20", bus.c);
    end
  endtask

  task automatic test_edge_operands();
    check_op("e_zero", 8'd200, 8'd0, 8'd13, 0);
    check_op("p_one", 8'd77, 8'd201, 8'd1, 0);
    check_op("m_zero_e_zero", 8'd0, 8'd0, 8'd11, 0);
    check_op("p_zero", 8'd9, 8'd4, 8'd0, 0);
    check_op("err_clear", 8'd5, 8'd3, 8'd7, 0);
`ifdef RSA_CONST_TIME_EN
    check_op("ct_5_128_7", 8'd5, 8'd128, 8'd7, 0);
`endif
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    saw_done = 1'b0;
    bus.m = 8'd5;
    bus.e = 8'd3;
    bus.p = 8'd7;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (39) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_vec++;
    if ({bus.busy, bus.done, bus.c} !== 10'd0) begin
      n_err++;
      $display("FAIL mid reset: got busy=%0b done=%0b c=%0d want 0", bus.busy, bus.done,
               bus.c);
    end
    repeat (120) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    n_vec++;
    if (saw_done) begin
      n_err++;
      $display("FAIL mid reset done: got pulse want none");
    end
    check_op("after_reset", 8'd5, 8'd3, 8'd7, 0);
  endtask

  task automatic test_back_to_back();
    check_op("b2b_a", 8'd3, 8'd10, 8'd17, 0);
    check_op("b2b_b", 8'd250, 8'd7, 8'd97, 0);
  endtask

  task automatic test_random();
    logic [7:0] rm;
    logic [7:0] re;
    logic [7:0] rp;
    for (int k = 0; k < 24; k++) begin
      rm = 8'($urandom);
      re = 8'($urandom);
      rp = (k % 8 == 7) ? 8'd0 : 8'($urandom_range(1, 255));
      check_op("random", rm, re, rp, 0);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_ignored_start();
    test_edge_operands();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
